// File: rtl/bsg_fsb_murn_commander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_fsb_murn_commander                                                     |
// | Master-side injector of FSB MURN switch-command packets; tracks a shadow   |
// | copy of each node's enable/reset state. Optional boot sequence is built    |
// | when BSG_FSB_MURN_COMMANDER_BOOT_EN is defined.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bsg_fsb_murn_commander #(
   parameter int width_p    = 32,
   parameter int id_width_p = 4,
   parameter int nodes_p    = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  cmd_v_i,
   input  logic [id_width_p-1:0] cmd_node_i,
   input  logic [1:0]            cmd_op_i,
   output logic                  cmd_ready_o,
   output logic                  v_o,
   output logic [width_p-1:0]    data_o,
   input  logic                  ready_i,
   output logic [nodes_p-1:0]    node_en_r_o,
   output logic [nodes_p-1:0]    node_reset_r_o,
   output logic                  boot_done_o,
   output logic                  err_o
);

   localparam logic [1:0] c_op_reset_on  = 2'd0;
   localparam logic [1:0] c_op_reset_off = 2'd1;
   localparam logic [1:0] c_op_enable    = 2'd2;
   localparam logic [1:0] c_op_disable   = 2'd3;

   localparam logic [id_width_p-1:0] c_last_node = id_width_p'(nodes_p - 1);
   localparam logic [id_width_p-1:0] c_num_nodes = id_width_p'(nodes_p);

   typedef enum logic [1:0] {BOOT, IDLE, SEND, BCAST} state_e;

   state_e                r_state;
   logic [id_width_p-1:0] r_cnt;
   logic                  r_v;
   logic                  r_ready;
   logic                  r_err;
   logic [width_p-1:0]    r_data;
   logic [nodes_p-1:0]    r_en;
   logic [nodes_p-1:0]    r_rst;

   logic [id_width_p-1:0] w_cur_id;
   logic [1:0]            w_cur_op;
   logic [id_width_p-1:0] w_cnt_nxt;
   logic [nodes_p-1:0]    w_sel;
   logic                  w_cmd_acc;
   logic                  w_cmd_valid;
   logic                  w_cmd_bcast;

   function automatic logic [width_p-1:0] f_pkt(input logic [id_width_p-1:0] id,
                                                input logic [1:0]            op);
      logic [width_p-1:0] p;
      p                           = '0;
      p[width_p-1 -: id_width_p]  = id;
      p[width_p-id_width_p-1]     = 1'b1;
      p[1:0]                      = op;
      return p;
   endfunction

`ifdef BSG_FSB_MURN_COMMANDER_BOOT_EN
   logic [1:0] r_phase;
   logic       r_boot_done;

   // Boot order: RESET_ON sweep, then ENABLE sweep, then RESET_OFF sweep.
   function automatic logic [1:0] f_boot_op(input logic [1:0] phase);
      case (phase)
         2'd0:    return c_op_reset_on;
         2'd1:    return c_op_enable;
         default: return c_op_reset_off;
      endcase
   endfunction

   assign boot_done_o = r_boot_done;
`else
   assign boot_done_o = 1'b1;
`endif

   // The outgoing packet itself carries the id/op used for the shadow update.
   assign w_cur_id    = r_data[width_p-1 -: id_width_p];
   assign w_cur_op    = r_data[1:0];
   assign w_cnt_nxt   = r_cnt + id_width_p'(1);
   assign w_cmd_acc   = cmd_v_i & r_ready;
   assign w_cmd_valid = (cmd_node_i < c_num_nodes);
   assign w_cmd_bcast = &cmd_node_i;

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < nodes_p; i++) begin
         w_sel[i] = (w_cur_id == id_width_p'(i));
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_en  <= '0;
         r_rst <= '1;
      end else if (r_v && ready_i) begin
         case (w_cur_op)
            c_op_reset_on:  r_rst <= r_rst | w_sel;
            c_op_reset_off: r_rst <= r_rst & ~w_sel;
            c_op_enable:    r_en  <= r_en | w_sel;
            c_op_disable:   r_en  <= r_en & ~w_sel;
            default:        r_en  <= r_en;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
`ifdef BSG_FSB_MURN_COMMANDER_BOOT_EN
         r_state     <= BOOT;
         r_phase     <= '0;
         r_boot_done <= 1'b0;
`else
         r_state     <= IDLE;
`endif
         r_cnt   <= '0;
         r_v     <= 1'b0;
         r_data  <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               r_ready <= 1'b1;
               if (w_cmd_acc) begin
                  if (w_cmd_valid) begin
                     r_state <= SEND;
                     r_v     <= 1'b1;
                     r_data  <= f_pkt(cmd_node_i, cmd_op_i);
                     r_ready <= 1'b0;
                  end else if (w_cmd_bcast) begin
                     r_state <= BCAST;
                     r_cnt   <= '0;
                     r_v     <= 1'b1;
                     r_data  <= f_pkt('0, cmd_op_i);
                     r_ready <= 1'b0;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (ready_i) begin
                  r_state <= IDLE;
                  r_v     <= 1'b0;
                  r_data  <= '0;
                  r_ready <= 1'b1;
               end
            end
            BCAST: begin
               if (ready_i) begin
                  if (r_cnt == c_last_node) begin
                     r_state <= IDLE;
                     r_v     <= 1'b0;
                     r_data  <= '0;
                     r_ready <= 1'b1;
                  end else begin
                     r_cnt  <= w_cnt_nxt;
                     r_data <= f_pkt(w_cnt_nxt, w_cur_op);
                  end
               end
            end
            BOOT: begin
`ifdef BSG_FSB_MURN_COMMANDER_BOOT_EN
               if (!r_v) begin
                  r_v     <= 1'b1;
                  r_cnt   <= '0;
                  r_phase <= '0;
                  r_data  <= f_pkt('0, c_op_reset_on);
               end else if (ready_i) begin
                  if (r_cnt != c_last_node) begin
                     r_cnt  <= w_cnt_nxt;
                     r_data <= f_pkt(w_cnt_nxt, w_cur_op);
                  end else if (r_phase != 2'd2) begin
                     r_phase <= r_phase + 2'd1;
                     r_cnt   <= '0;
                     r_data  <= f_pkt('0, f_boot_op(r_phase + 2'd1));
                  end else begin
                     r_state     <= IDLE;
                     r_v         <= 1'b0;
                     r_data      <= '0;
                     r_ready     <= 1'b1;
                     r_boot_done <= 1'b1;
                  end
               end
`else
               r_state <= IDLE;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cmd_ready_o    = r_ready;
   assign v_o            = r_v;
   assign data_o         = r_data;
   assign err_o          = r_err;
   assign node_en_r_o    = r_en;
   assign node_reset_r_o = r_rst;

endmodule
`default_nettype wire
